// File: rtl/start_dispatcher_if.sv
// Handshake bundle between the job producer, the start_dispatcher, the downstream
// Counter and the completion consumer. The master modport is the dispatcher's view.
interface start_dispatcher_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 8
);
    logic                         request__ENA;
    logic [TAG_WIDTH-1:0]         request_tag;
    logic                         request__RDY;
    logic                         startSignal__ENA;
    logic                         startSignal__RDY;
    logic                         done__ENA;
    logic [TAG_WIDTH-1:0]         done_tag;
    logic                         done__RDY;
    logic [$clog2(DEPTH+1)-1:0]   pending;

    modport master (
        input  request__ENA, request_tag, startSignal__RDY, done__RDY,
        output request__RDY, startSignal__ENA, done__ENA, done_tag, pending
    );

    modport slave (
        output request__ENA, request_tag, startSignal__RDY, done__RDY,
        input  request__RDY, startSignal__ENA, done__ENA, done_tag, pending
    );
endinterface

// File: rtl/start_dispatcher.sv
// Job front-end for Counter: buffers tagged start requests in a FIFO, issues them one at
// a time to Counter.startSignal and reports each completion with its tag via done.
module start_dispatcher #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    start_dispatcher_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t               state_r;
    logic [TAG_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [CNT_W-1:0]     count_r;
    logic [TAG_WIDTH-1:0] inflight_tag_r;

    logic                 not_full_s;
    logic                 not_empty_s;
    logic                 push_s;
    logic                 issue_s;

    // Readiness comes from the registered count only, so a full FIFO refuses a push
    // even in a cycle that also pops.
    assign not_full_s  = (count_r < FULL_CNT);
    assign not_empty_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = bus.request__ENA && not_full_s;

    // Issue a queued job when Counter is idle and no completion is still waiting to be taken.
    always_comb begin
        issue_s = 1'b0;
        case (state_r)
            IDLE:    issue_s = not_empty_s && bus.startSignal__RDY;
            REPORT:  issue_s = not_empty_s && bus.startSignal__RDY && bus.done__RDY;
            default: issue_s = 1'b0;
        endcase
    end

    // Tag storage, written at the tail on every accepted push.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {TAG_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[tail_r] <= bus.request_tag;
        end else begin
            mem_r[tail_r] <= mem_r[tail_r];
        end
    end

    // Head/tail pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end
            if (issue_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            case ({push_s, issue_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Job sequencer: exactly one job in flight; the tag is latched as the job leaves the FIFO.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r        <= IDLE;
            inflight_tag_r <= {TAG_WIDTH{1'b0}};
        end else begin
            if (issue_s) begin
                inflight_tag_r <= mem_r[head_r];
            end
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (bus.startSignal__RDY) begin
                        state_r <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.done__RDY) begin
                        state_r <= issue_s ? RUN : IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.request__RDY     = not_full_s;
    assign bus.startSignal__ENA = issue_s;
    assign bus.done__ENA        = (state_r == REPORT) && bus.done__RDY;
    assign bus.done_tag         = inflight_tag_r;
    assign bus.pending          = count_r;
endmodule

// File: tb/tb_start_dispatcher.sv
// Bench for start_dispatcher paired with a behavioural Counter; a queue-based timing model
// predicts every handshake output cycle by cycle.
module tb_start_dispatcher;
    localparam int DEPTH = 4;
    localparam int TW    = 8;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    start_dispatcher_if #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) bus ();
    start_dispatcher #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    // Behavioural Counter: loads MAX_AMOUNT-1 on start, counts down, ready at zero.
    int max_amount = 22;
    int cnt;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                     cnt <= 0;
        else if (bus.startSignal__ENA) cnt <= max_amount - 1;
        else if (cnt != 0)             cnt <= cnt - 1;
    end
    assign bus.startSignal__RDY = (cnt == 0);

    int checks = 0;
    int errors = 0;

    // Reference model: queued tags plus the cycle at which the in-flight job becomes reportable.
    logic [TW-1:0] q[$];
    bit            m_busy;
    logic [TW-1:0] m_tag;
    int            m_ready;
    int            cyc;
    bit            m_report, exp_done, exp_issue, exp_rdy;
    logic [2:0]    exp_pending;

    int            ev_start[$];
    int            ev_done[$];
    logic [TW-1:0] ev_tag[$];

    task automatic sample();
        @(negedge CLK);
        m_report    = m_busy && (cyc >= m_ready);
        exp_done    = m_report && bus.done__RDY;
        exp_issue   = (q.size() != 0) && (!m_busy || exp_done);
        exp_rdy     = (q.size() < DEPTH);
        exp_pending = 3'(q.size());
        if (bus.startSignal__ENA) ev_start.push_back(cyc);
        if (bus.done__ENA) begin
            ev_done.push_back(cyc);
            ev_tag.push_back(bus.done_tag);
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        if (exp_done) m_busy = 1'b0;
        if (exp_issue) begin
            m_tag   = q.pop_front();
            m_busy  = 1'b1;
            m_ready = cyc + max_amount + 1;
        end
        if (bus.request__ENA && exp_rdy) q.push_back(bus.request_tag);
        cyc++;
        #1;
    endtask

    function automatic logic [5:0] got_vec();
        return {bus.request__RDY, bus.pending, bus.startSignal__ENA, bus.done__ENA};
    endfunction

    function automatic logic [5:0] exp_vec();
        return {exp_rdy, exp_pending, exp_issue, exp_done};
    endfunction

    task automatic do_reset(input int m);
        bus.request__ENA = 1'b0;
        bus.request_tag  = 8'h00;
        bus.done__RDY    = 1'b1;
        nRST             = 1'b0;
        max_amount       = m;
        repeat (2) @(posedge CLK);
        q.delete();
        m_busy = 1'b0;
        m_tag  = 8'h00;
        cyc    = 0;
        ev_start.delete();
        ev_done.delete();
        ev_tag.delete();
        #1 nRST = 1'b1;
    endtask

    task automatic test_reset();
        bus.request__ENA = 1'b0;
        bus.request_tag  = 8'h00;
        bus.done__RDY    = 1'b1;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.request__RDY, bus.startSignal__ENA, bus.done__ENA, bus.done_tag, bus.pending}
            !== {1'b1, 1'b0, 1'b0, 8'h00, 3'd0})
            begin errors++; $display("FAIL reset_values: got rdy=%b start=%b done=%b tag=%h pend=%0d", bus.request__RDY, bus.startSignal__ENA, bus.done__ENA, bus.done_tag, bus.pending); end
        do_reset(22);
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL reset_idle: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            advance();
        end
    endtask

    task automatic test_single();
        do_reset(22);
        for (int i = 0; i < 40; i++) begin
            bus.request__ENA = (i == 0);
            bus.request_tag  = (i == 0) ? 8'h5A : 8'h00;
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL single: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            if (m_report) begin
                checks++;
                if (bus.done_tag !== m_tag) begin errors++; $display("FAIL single_tag: cyc %0d got %h expected %h", cyc, bus.done_tag, m_tag); end
            end
            advance();
        end
        checks++;
        if (ev_start.size() != 1 || ev_start[0] != 1) begin errors++; $display("FAIL single_start: %0d starts, first at %0d, expected one at 1", ev_start.size(), (ev_start.size() > 0) ? ev_start[0] : -1); end
        checks++;
        if (ev_done.size() != 1 || ev_done[0] != 24 || ev_tag[0] !== 8'h5A) begin errors++; $display("FAIL single_done: %0d dones, first at %0d, expected one at 24 tag 5a", ev_done.size(), (ev_done.size() > 0) ? ev_done[0] : -1); end
    endtask

    task automatic test_full();
        do_reset(22);
        for (int i = 0; i < 130; i++) begin
            bus.request__ENA = (i < 6);
            bus.request_tag  = 8'(i + 1);
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL full: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            if (m_report) begin
                checks++;
                if (bus.done_tag !== m_tag) begin errors++; $display("FAIL full_tag: cyc %0d got %h expected %h", cyc, bus.done_tag, m_tag); end
            end
            if (i == 5) begin
                checks++;
                if (bus.request__RDY !== 1'b0 || bus.pending !== 3'd4) begin errors++; $display("FAIL full_refuse: rdy=%b pending=%0d, expected rdy=0 pending=4", bus.request__RDY, bus.pending); end
            end
            advance();
        end
        checks++;
        if (ev_done.size() != 5) begin errors++; $display("FAIL full_count: %0d completions, expected 5", ev_done.size()); end
        for (int k = 0; k < ev_done.size() && k < 5; k++) begin
            checks++;
            if (ev_tag[k] !== 8'(k + 1) || ev_done[k] != 24 + 23 * k) begin errors++; $display("FAIL full_order: done %0d tag %h at %0d, expected tag %0d at %0d", k, ev_tag[k], ev_done[k], k + 1, 24 + 23 * k); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(5);
        bus.done__RDY = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.request__ENA = (i < 3);
            bus.request_tag  = 8'(8'h11 * (i + 1));
            if (i == 15) bus.done__RDY = 1'b1;
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL backpressure: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            if (m_report) begin
                checks++;
                if (bus.done_tag !== m_tag) begin errors++; $display("FAIL bp_tag: cyc %0d got %h expected %h", cyc, bus.done_tag, m_tag); end
            end
            if (i == 15) begin
                checks++;
                if ({bus.done__ENA, bus.startSignal__ENA, bus.done_tag} !== {1'b1, 1'b1, 8'h11}) begin errors++; $display("FAIL bp_release: done=%b start=%b tag=%h, expected 1 1 11", bus.done__ENA, bus.startSignal__ENA, bus.done_tag); end
            end
            advance();
        end
        checks++;
        if (ev_start.size() != 3 || ev_start[0] != 1 || ev_start[1] != 15 || ev_start[2] != 21) begin errors++; $display("FAIL bp_starts: %0d starts, expected at 1,15,21", ev_start.size()); end
        checks++;
        if (ev_done.size() != 3 || ev_done[0] != 15 || ev_done[1] != 21 || ev_done[2] != 27) begin errors++; $display("FAIL bp_dones: %0d dones, expected at 15,21,27", ev_done.size()); end
    endtask

    task automatic test_max1();
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            bus.request__ENA = (i < 2);
            bus.request_tag  = 8'(7 + i);
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL max1: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            advance();
        end
        checks++;
        if (ev_done.size() != 2 || ev_start.size() != 2) begin errors++; $display("FAIL max1_count: %0d starts %0d dones, expected 2 and 2", ev_start.size(), ev_done.size()); end
        for (int k = 0; k < ev_done.size() && k < ev_start.size() && k < 2; k++) begin
            checks++;
            if (ev_done[k] - ev_start[k] != 2 || ev_tag[k] !== 8'(7 + k)) begin errors++; $display("FAIL max1_job: job %0d tag %h latency %0d, expected tag %0d latency 2", k, ev_tag[k], ev_done[k] - ev_start[k], 7 + k); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(6);
        for (int i = 0; i < 5; i++) begin
            bus.request__ENA = (i < 4);
            bus.request_tag  = 8'(8'hA0 + i);
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL mid_pre: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            advance();
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({bus.pending, bus.request__RDY, bus.startSignal__ENA, bus.done__ENA, bus.done_tag} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL mid_reset: pend=%0d rdy=%b start=%b done=%b tag=%h, expected 0 1 0 0 00", bus.pending, bus.request__RDY, bus.startSignal__ENA, bus.done__ENA, bus.done_tag); end
        do_reset(6);
        for (int i = 0; i < 30; i++) begin
            bus.request__ENA = (i == 15);
            bus.request_tag  = 8'hC3;
            sample();
            checks++;
            if (got_vec() !== exp_vec()) begin errors++; $display("FAIL mid_post: cyc %0d got %b expected %b", cyc, got_vec(), exp_vec()); end
            advance();
        end
        checks++;
        if (ev_done.size() != 1 || ev_done[0] != 23 || ev_tag[0] !== 8'hC3) begin errors++; $display("FAIL mid_fresh: %0d dones, first at %0d, expected one at 23 tag c3", ev_done.size(), (ev_done.size() > 0) ? ev_done[0] : -1); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset(int'($urandom_range(1, 4)));
            for (int i = 0; i < 200; i++) begin
                bus.request__ENA = ($urandom_range(0, 2) != 0);
                bus.request_tag  = 8'($urandom_range(0, 255));
                bus.done__RDY    = ($urandom_range(0, 3) != 0);
                sample();
                checks++;
                if (got_vec() !== exp_vec()) begin errors++; $display("FAIL random: round %0d cyc %0d got %b expected %b", r, cyc, got_vec(), exp_vec()); end
                if (m_report) begin
                    checks++;
                    if (bus.done_tag !== m_tag) begin errors++; $display("FAIL random_tag: cyc %0d got %h expected %h", cyc, bus.done_tag, m_tag); end
                end
                advance();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_backpressure();
        test_max1();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
